lane_signal_controller: RTL and testbench

- Consumes the four per-lane 4-bit density counts from the lane count generator.
- Turns them into a round-robin traffic-light sequence: GREEN, then YELLOW, then ALL_RED for each lane.
- Green time scales with the lane's sampled count. Empty lanes are skipped.
- Sits downstream of the count generator; drives the lamp outputs of the four-way junction.

---
 rtl/lane_signal_controller.sv | 207 ++++++++++++++++++++
 tb/tb_lane_signal_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_signal_controller.sv
// Round-robin four-way junction lamp controller: GREEN -> YELLOW -> ALL_RED per lane, green time scaled by lane density.
// Optional emergency preemption is enabled by defining EMERGENCY_PREEMPT_EN.
module lane_signal_controller #(
    parameter int TIMER_W       = 8,
    parameter int MIN_GREEN     = 4,
    parameter int GREEN_PER_CAR = 2,
    parameter int MAX_GREEN     = 30,
    parameter int YELLOW_TIME   = 3,
    parameter int ALL_RED_TIME  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [3:0]         count1,
    input  logic [3:0]         count2,
    input  logic [3:0]         count3,
    input  logic [3:0]         count4,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic               emerg_req,
    input  logic [1:0]         emerg_lane,
`endif
    output logic [3:0]         green,
    output logic [3:0]         yellow,
    output logic [3:0]         red,
    output logic [1:0]         active_lane,
    output logic [TIMER_W-1:0] green_time,
    output logic [TIMER_W-1:0] timer,
    output logic               phase_start,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_t;

    localparam int WIDE = TIMER_W + 4;
    localparam logic [TIMER_W-1:0] MAX_G    = TIMER_W'(MAX_GREEN);
    localparam logic [TIMER_W-1:0] YELLOW_T = TIMER_W'(YELLOW_TIME);
    localparam logic [TIMER_W-1:0] ALLRED_T = TIMER_W'(ALL_RED_TIME);
    localparam logic [TIMER_W-1:0] ONE_T    = TIMER_W'(1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         lane_q, lane_d;
    logic [TIMER_W-1:0] gt_q, gt_d;
    logic               ps_q, ps_d;
    logic [3:0]         green_q, green_d;
    logic [3:0]         yellow_q, yellow_d;
    logic [3:0]         red_q, red_d;

    logic [3:0]         cnt [4];
    logic [3:0]         nz;
    logic [1:0]         lane_sel;
    logic [1:0]         cand;
    logic               found;
    logic [WIDE-1:0]    gt_wide;
    logic [TIMER_W-1:0] gt_calc;
    logic               expire;
    logic               dec;
    logic               preempt;
    logic               hold;
    logic               pend;
    logic [1:0]         pend_lane;

    assign cnt[0] = count1;
    assign cnt[1] = count2;
    assign cnt[2] = count3;
    assign cnt[3] = count4;

`ifdef EMERGENCY_PREEMPT_EN
    logic       pend_q, pend_d;
    logic [1:0] plane_q, plane_d;

    assign preempt   = (state_q == ST_GREEN) && emerg_req && (emerg_lane != lane_q);
    assign hold      = (state_q == ST_GREEN) && emerg_req && (emerg_lane == lane_q);
    assign pend      = pend_q;
    assign pend_lane = plane_q;

    // The preempting lane is latched so it survives the request dropping during YELLOW/ALL_RED.
    always_comb begin
        pend_d  = pend_q;
        plane_d = plane_q;
        if (preempt) begin
            pend_d  = 1'b1;
            plane_d = emerg_lane;
        end else if (state_q == ST_ALL_RED && expire) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            plane_q <= 2'd0;
        end else begin
            pend_q  <= pend_d;
            plane_q <= plane_d;
        end
    end
`else
    assign preempt   = 1'b0;
    assign hold      = 1'b0;
    assign pend      = 1'b0;
    assign pend_lane = 2'd0;
`endif

    // Round-robin search starting after the last served lane; k==4 revisits the same lane.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nz[i] = |cnt[i];
        end
        lane_sel = lane_q + 2'd1;
        found    = 1'b0;
        cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = lane_q + 2'(k);
            if (!found && nz[cand]) begin
                lane_sel = cand;
                found    = 1'b1;
            end
        end
        gt_wide = WIDE'(MIN_GREEN) + WIDE'(cnt[lane_sel]) * WIDE'(GREEN_PER_CAR);
        gt_calc = (gt_wide > WIDE'(MAX_GREEN)) ? MAX_G : gt_wide[TIMER_W-1:0];
    end

    assign expire = tick && (timer_q <= ONE_T);
    assign dec    = tick && (timer_q > ONE_T);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lane_d  = lane_q;
        gt_d    = gt_q;
        ps_d    = 1'b0;
        case (state_q)
            ST_ALL_RED: begin
                if (expire) begin
                    lane_d  = pend ? pend_lane : lane_sel;
                    gt_d    = pend ? MAX_G : gt_calc;
                    timer_d = gt_d;
                    state_d = ST_GREEN;
                    ps_d    = 1'b1;
                end else if (dec) begin
                    timer_d = timer_q - ONE_T;
                end
            end
            ST_GREEN: begin
                if (preempt || (!hold && expire)) begin
                    state_d = ST_YELLOW;
                    timer_d = YELLOW_T;
                end else if (!hold && dec) begin
                    timer_d = timer_q - ONE_T;
                end
            end
            ST_YELLOW: begin
                if (expire) begin
                    state_d = ST_ALL_RED;
                    timer_d = ALLRED_T;
                end else if (dec) begin
                    timer_d = timer_q - ONE_T;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                timer_d = ALLRED_T;
            end
        endcase

        green_d  = (state_d == ST_GREEN)  ? (4'b0001 << lane_d) : 4'b0000;
        yellow_d = (state_d == ST_YELLOW) ? (4'b0001 << lane_d) : 4'b0000;
        red_d    = ~(green_d | yellow_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ALL_RED;
            timer_q  <= ALLRED_T;
            lane_q   <= 2'd3;
            gt_q     <= '0;
            ps_q     <= 1'b0;
            green_q  <= 4'b0000;
            yellow_q <= 4'b0000;
            red_q    <= 4'b1111;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            lane_q   <= lane_d;
            gt_q     <= gt_d;
            ps_q     <= ps_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
        end
    end

    assign green       = green_q;
    assign yellow      = yellow_q;
    assign red         = red_q;
    assign active_lane = lane_q;
    assign green_time  = gt_q;
    assign timer       = timer_q;
    assign phase_start = ps_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lane_signal_controller.sv
// Bench for lane_signal_controller: phase-level reference model feeding an expected queue, checked by a lamp monitor.
// Define EMERGENCY_PREEMPT_EN to also exercise preemption and hold.
module tb_lane_signal_controller;

    localparam int TIMER_W       = 8;
    localparam int MIN_GREEN     = 4;
    localparam int GREEN_PER_CAR = 2;
    localparam int MAX_GREEN     = 30;
    localparam int YELLOW_TIME   = 3;
    localparam int ALL_RED_TIME  = 1;
    localparam int EW            = 47;

    logic               clk = 1'b0;
    logic               rst;
    logic               tick;
    logic [3:0]         count1, count2, count3, count4;
    logic               emerg_req;
    logic [1:0]         emerg_lane;
    logic [3:0]         green, yellow, red;
    logic [1:0]         active_lane;
    logic [TIMER_W-1:0] green_time, timer;
    logic               phase_start;
    logic [1:0]         dbg_state;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q [$];

    // Model: phase 0 = all-red, 1 = green, 2 = yellow; rem = ticks left in the phase.
    int m_phase, m_rem, m_lane, m_gt, m_plane;
    bit m_pend;

    lane_signal_controller #(
        .TIMER_W(TIMER_W), .MIN_GREEN(MIN_GREEN), .GREEN_PER_CAR(GREEN_PER_CAR),
        .MAX_GREEN(MAX_GREEN), .YELLOW_TIME(YELLOW_TIME), .ALL_RED_TIME(ALL_RED_TIME)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .count1(count1),
        .count2(count2),
        .count3(count3),
        .count4(count4),
`ifdef EMERGENCY_PREEMPT_EN
        .emerg_req(emerg_req),
        .emerg_lane(emerg_lane),
`endif
        .green(green),
        .yellow(yellow),
        .red(red),
        .active_lane(active_lane),
        .green_time(green_time),
        .timer(timer),
        .phase_start(phase_start),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [EW-1:0] pack(int c, logic [3:0] g, logic [3:0] y, logic [3:0] r,
                                           logic [1:0] l, logic [7:0] gt, logic [7:0] tm, logic ps);
        return {16'(c), g, y, r, l, gt, tm, ps};
    endfunction

    function automatic int green_for(int c);
        int v;
        v = MIN_GREEN + c * GREEN_PER_CAR;
        return (v > MAX_GREEN) ? MAX_GREEN : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_rem   = ALL_RED_TIME;
        m_lane  = 3;
        m_gt    = 0;
        m_pend  = 1'b0;
        m_plane = 0;
    endtask

    // Predicts the effect of the coming clock edge from the inputs now being driven.
    task automatic model_edge(input bit t);
        int  c [4];
        bit  moved;
        bit  found;
        int  idx;
        logic [3:0] g, y;
        c[0] = count1; c[1] = count2; c[2] = count3; c[3] = count4;
        moved = 1'b0;
        if (m_phase == 1 && emerg_req && emerg_lane != 2'(m_lane)) begin
            m_phase = 2; m_rem = YELLOW_TIME; m_pend = 1'b1; m_plane = emerg_lane; moved = 1'b1;
        end else if (m_phase == 1 && emerg_req) begin
            moved = 1'b0;
        end else if (t) begin
            if (m_rem > 1) begin
                m_rem--;
            end else begin
                moved = 1'b1;
                if (m_phase == 0) begin
                    if (m_pend) begin
                        m_lane = m_plane; m_gt = MAX_GREEN; m_pend = 1'b0;
                    end else begin
                        found = 1'b0;
                        idx   = (m_lane + 1) % 4;
                        for (int k = 1; k <= 4; k++) begin
                            if (!found && c[(m_lane + k) % 4] != 0) begin
                                idx = (m_lane + k) % 4; found = 1'b1;
                            end
                        end
                        m_lane = idx;
                        m_gt   = green_for(c[idx]);
                    end
                    m_phase = 1; m_rem = m_gt;
                end else if (m_phase == 1) begin
                    m_phase = 2; m_rem = YELLOW_TIME;
                end else begin
                    m_phase = 0; m_rem = ALL_RED_TIME;
                end
            end
        end
        if (moved) begin
            g = 4'b0000; y = 4'b0000;
            if (m_phase == 1) g[m_lane] = 1'b1;
            if (m_phase == 2) y[m_lane] = 1'b1;
            exp_q.push_back(pack(cyc + 1, g, y, ~(g | y), 2'(m_lane), 8'(m_gt), 8'(m_rem), m_phase == 1));
        end
    endtask

    task automatic step(input bit t);
        tick = t;
        model_edge(t);
        @(negedge clk);
    endtask

    task automatic set_counts(input int a, input int b, input int c, input int d);
        count1 = 4'(a); count2 = 4'(b); count3 = 4'(c); count4 = 4'(d);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_green"}, 32'(green), 32'h0);
        chk({tag, "_yellow"}, 32'(yellow), 32'h0);
        chk({tag, "_red"}, 32'(red), 32'hf);
        chk({tag, "_timer"}, 32'(timer), 32'(ALL_RED_TIME));
        chk({tag, "_lane"}, 32'(active_lane), 32'd3);
        chk({tag, "_green_time"}, 32'(green_time), 32'h0);
        chk({tag, "_phase_start"}, 32'(phase_start), 32'h0);
        chk({tag, "_state"}, 32'(dbg_state), 32'h0);
    endtask

    // Called at a falling edge; the monitor samples that edge before reset lands.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_values(tag);
        model_reset();
        tick = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // Monitor: every lamp change must match the oldest expected phase entry, cycle-exact.
    initial begin : monitor
        logic [11:0]   prev_l, cur_l;
        logic [EW-1:0] act, e;
        prev_l = 12'h00f;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_l = 12'h00f;
            end else begin
                cur_l = {green, yellow, red};
                tests++;
                if (((green | yellow) & red) != 4'b0 || $countones(green | yellow) > 1 || red != ~(green | yellow)) begin
                    fails++;
                    $display("FAIL lamp_exclusive actual g=%b y=%b r=%b required one lane non-red, red=~(g|y)", green, yellow, red);
                end
                if (cur_l != prev_l) begin
                    act = pack(cyc, green, yellow, red, active_lane, green_time, timer, phase_start);
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL phase_unexpected actual=%h expected=none (cyc %0d)", act, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e !== act) begin
                            fails++;
                            $display("FAIL phase_change actual=%h expected=%h (cyc|g|y|r|lane|gt|tm|ps)", act, e);
                        end
                    end
                end else begin
                    tests++;
                    if (phase_start !== 1'b0) begin
                        fails++;
                        $display("FAIL phase_start_width actual=%b expected=0 (cyc %0d)", phase_start, cyc);
                    end
                end
                prev_l = cur_l;
            end
        end
    end

    initial begin : stimulus
        int guard;
        int lane_hold;
        rst = 1'b0; tick = 1'b0; emerg_req = 1'b0; emerg_lane = 2'd0;
        set_counts(0, 0, 0, 0);
        model_reset();
        #1 rst = 1'b1;
        #3 check_reset_values("reset");
        @(negedge clk);
        #2 rst = 1'b0;

        // Mixed densities: lane1 skipped, lane3 clamped, then wrap.
        set_counts(5, 0, 3, 15);
        repeat (110) step(1'b1);

        // Empty junction: plain rotation with minimum green.
        set_counts(0, 0, 0, 0);
        repeat (45) step(1'b1);

        // Single busy lane served on every cycle of the sequence.
        set_counts(0, 0, 2, 0);
        repeat (60) step(1'b1);

        // Timebase stall mid-green.
        set_counts(3, 1, 4, 2);
        guard = 0;
        while (!(m_phase == 1 && m_rem > 5) && guard < 200) begin
            step(1'b1); guard++;
        end
        chk("freeze_reach_green", 32'(guard < 200), 32'd1);
        repeat (50) step(1'b0);
        chk("freeze_timer", 32'(timer), 32'(m_rem));
        chk("freeze_green", 32'(green), 32'(4'b0001 << m_lane));
        repeat (40) step(1'b1);

        // Randomised densities and timebase.
        repeat (600) begin
            if ($urandom_range(0, 7) == 0) begin
                count1 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                count2 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                count3 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                count4 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end
            step($urandom_range(0, 3) != 0);
        end

        // Reset while lane3 is yellow; the sequence restarts at lane0.
        set_counts(7, 7, 7, 7);
        guard = 0;
        while (!(m_phase == 2 && m_lane == 3) && guard < 300) begin
            step(1'b1); guard++;
        end
        chk("yellow3_reached", 32'(guard < 300), 32'd1);
        do_reset("midreset");
        repeat (30) step(1'b1);

`ifdef EMERGENCY_PREEMPT_EN
        do_reset("emreset");
        set_counts(5, 0, 3, 15);
        guard = 0;
        while (!(m_phase == 1 && m_lane == 0 && m_rem == 9) && guard < 100) begin
            step(1'b1); guard++;
        end
        chk("emerg_reach", 32'(guard < 100), 32'd1);
        emerg_req = 1'b1; emerg_lane = 2'd2;
        step(1'b1);
        emerg_req = 1'b0;
        repeat (10) step(1'b1);
        chk("emerg_lane2_gt", 32'(green_time), 32'(MAX_GREEN));
        repeat (20) step(1'b1);
        guard = 0;
        while (!(m_phase == 1 && m_rem > 4) && guard < 200) begin
            step(1'b1); guard++;
        end
        lane_hold  = m_lane;
        emerg_lane = 2'(lane_hold);
        emerg_req  = 1'b1;
        repeat (12) step(1'b1);
        chk("emerg_hold_timer", 32'(timer), 32'(m_rem));
        emerg_req = 1'b0;
        repeat (60) step(1'b1);
`endif

        repeat (3) step(1'b0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
